// File: rtl/prbs31_chk_pkg.sv
// Shared types and sizing constants for the PRBS31 checker and its step function.
package prbs31_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } chk_state_t;

    localparam int PRBS_LEN   = 31;
    localparam int TAP_A      = 27;
    localparam int TAP_B      = 30;

    localparam int VERIFY_LEN = 64;
    localparam int WIN_LEN    = 64;
    localparam int LOL_THRESH = 8;
    localparam int ERR_CNT_W  = 8;

    localparam int FILL_W     = $clog2(PRBS_LEN);
    localparam int MATCH_W    = $clog2(VERIFY_LEN);
    localparam int WIN_W      = $clog2(WIN_LEN);
    localparam int WIN_ERR_W  = $clog2(LOL_THRESH + 1);

endpackage

// File: rtl/prbs31_step.sv
// One combinational step of the x^31+x^28+1 recurrence; bit 0 of the state is the newest bit.
module prbs31_step
    import prbs31_chk_pkg::*;
(
    input  logic [PRBS_LEN-1:0] cur,
    output logic [PRBS_LEN-1:0] nxt,
    output logic                bit_out
);

    assign bit_out = cur[TAP_A] ^ cur[TAP_B];
    assign nxt     = {cur[PRBS_LEN-2:0], bit_out};

endmodule

// File: rtl/tt_um_davidparent_prbs31_chk.sv
// PRBS31 checker: HUNT (fill history) | VERIFY (64 clean matches) | LOCKED (count errors, windowed loss of lock).
// Optional internal loopback generator is enabled by defining PRBS31_CHK_SELFTEST_EN.
module tt_um_davidparent_prbs31_chk
    import prbs31_chk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    input  logic       ena,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [FILL_W-1:0]    FILL_LAST  = FILL_W'(PRBS_LEN - 1);
    localparam logic [MATCH_W-1:0]   MATCH_LAST = MATCH_W'(VERIFY_LEN - 1);
    localparam logic [WIN_W-1:0]     WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [WIN_ERR_W-1:0] LOL_LIMIT  = WIN_ERR_W'(LOL_THRESH);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

    logic clr, inv, rx, d, p, mism;
    logic unused_ok;

    assign clr = ui_in[1];
    assign inv = ui_in[2];

`ifdef PRBS31_CHK_SELFTEST_EN
    logic [PRBS_LEN-1:0] gen_q, gen_d;
    logic                gen_bit;

    prbs31_step u_gen (
        .cur    (gen_q),
        .nxt    (gen_d),
        .bit_out(gen_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gen_q <= PRBS_LEN'(1);
        else        gen_q <= gen_d;
    end

    assign rx        = ui_in[3] ? (gen_bit ^ ui_in[4]) : ui_in[0];
    assign unused_ok = ^{uio_in, ena, ui_in[7:5]};
`else
    assign rx        = ui_in[0];
    assign unused_ok = ^{uio_in, ena, ui_in[7:3]};
`endif

    chk_state_t           state_q, state_d;
    logic [PRBS_LEN-1:0]  h_q, h_d, h_shift_d, h_pred;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [WIN_ERR_W-1:0] win_err_q, win_err_d, win_err_sum;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_q, err_d, err_inc;

    prbs31_step u_pred (
        .cur    (h_q),
        .nxt    (h_pred),
        .bit_out(p)
    );

    assign d           = rx ^ inv;
    assign mism        = d ^ p;
    assign h_shift_d   = {h_q[PRBS_LEN-2:0], d};
    assign win_err_sum = win_err_q + WIN_ERR_W'(mism);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            h_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_q     <= '0;
            win_err_q <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            win_err_q <= win_err_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_d     = win_q;
        win_err_d = win_err_q;
        err_d     = 1'b0;
        err_inc   = 1'b0;

        case (state_q)
            HUNT: begin
                h_d = h_shift_d;
                if (fill_q == FILL_LAST) begin
                    state_d = VERIFY;
                    fill_d  = '0;
                    match_d = '0;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            VERIFY: begin
                h_d = h_shift_d;
                if (mism) begin
                    state_d = HUNT;
                    fill_d  = '0;
                end else if (match_q == MATCH_LAST) begin
                    // an all-zero history satisfies the recurrence trivially, so it must not lock
                    if (h_shift_d == '0) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else begin
                        state_d   = LOCKED;
                        win_d     = '0;
                        win_err_d = '0;
                    end
                end else begin
                    match_d = match_q + 1'b1;
                end
            end
            LOCKED: begin
                // free-wheel on the prediction so a received error never enters the history
                h_d     = h_pred;
                err_d   = mism;
                err_inc = mism;
                win_d   = (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
                if (win_err_sum == LOL_LIMIT) begin
                    state_d = HUNT;
                    fill_d  = '0;
                end else if (win_q == WIN_LAST) begin
                    win_err_d = '0;
                end else begin
                    win_err_d = win_err_sum;
                end
            end
            default: begin
                state_d = HUNT;
                fill_d  = '0;
            end
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr)                              err_cnt_d = '0;
        else if (err_inc && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
    end

    assign uo_out  = {4'b0000, state_q, err_q, (state_q == LOCKED)};
    assign uio_out = err_cnt_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_davidparent_prbs31_chk.sv
// Scoreboard bench for the PRBS31 checker: stimulus pushes expected err_cnt per injected error, a monitor pops on err.
module tb_tt_um_davidparent_prbs31_chk;

    localparam int SEQ_N = 40000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic       ena = 1'b1;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_davidparent_prbs31_chk dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .ena    (ena),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference stream: s[0..30] is the pre-history implied by seed 1, stream bit n is s[n+31]
    logic s [0:SEQ_N+30];
    int   pos;
    logic inv_stream;

    // behavioural checker model: 95 clean bits to lock, 8 errors inside one 64-bit window to lose it
    int model_locked, clean_run, lock_age, win_flips, exp_cnt;
    int exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic b);
        ui_in[0] = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic flip_req);
        logic flip, b;
        flip = flip_req && (model_locked != 0);
        b    = s[pos+31] ^ inv_stream;
        pos++;
        if (model_locked != 0) begin
            if (flip) begin
                exp_cnt = ui_in[1] ? 0 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
                exp_q.push_back(exp_cnt);
                win_flips++;
            end else if (ui_in[1]) begin
                exp_cnt = 0;
            end
            if (win_flips == 8) begin
                model_locked = 0;
                clean_run    = 0;
            end else if (lock_age % 64 == 63) begin
                win_flips = 0;
            end
            lock_age++;
        end else begin
            if (ui_in[1]) exp_cnt = 0;
            clean_run++;
            if (clean_run == 95) begin
                model_locked = 1;
                lock_age     = 0;
                win_flips    = 0;
            end
        end
        drive(b ^ flip);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_uo_out"}, uo_out, 0);
        check({tag, "_uio_out"}, uio_out, 0);
        check({tag, "_uio_oe"}, uio_oe, 8'hFF);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        pos = 0; model_locked = 0; clean_run = 0; lock_age = 0; win_flips = 0; exp_cnt = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: every err pulse must match the next expected error count
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (uo_out[1] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL err_pulse: unexpected err pulse with err_cnt %0d, expected none", uio_out);
                end else begin
                    check("err_cnt_at_err", uio_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int bad, gap;
        for (int i = 0; i < 31; i++) s[i] = (i == 30);
        for (int i = 31; i <= SEQ_N + 30; i++) s[i] = s[i-28] ^ s[i-31];
        inv_stream = 1'b0;

        // clean stream locks on the 95th edge
        do_reset();
        repeat (94) send(1'b0);
        check("locked_after_94", uo_out[0], 0);
        send(1'b0);
        check("locked_after_95", uo_out[0], model_locked);
        check("state_code_locked", uo_out[3:2], 2'b10);

        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            send(1'b0);
            if (uo_out[0] !== 1'b1) bad++;
        end
        check("clean_lock_held", bad, 0);
        check("clean_err_cnt", uio_out, 0);

        // single flipped bit
        repeat ($urandom_range(1, 40)) send(1'b0);
        send(1'b1);
        repeat (40) send(1'b0);
        check("single_err_cnt", uio_out, exp_cnt);
        check("single_locked", uo_out[0], 1);

        ui_in[1] = 1'b1;
        send(1'b0);
        ui_in[1] = 1'b0;
        check("clr_err_cnt", uio_out, 0);

        // eight consecutive flips at the start of a fresh window lose lock
        bad = 1;
        for (int i = 0; i < 200; i++) begin
            if (lock_age % 64 == 8 && win_flips == 0) begin
                bad = 0;
                break;
            end
            send(1'b0);
        end
        check("window_align_reached", bad, 0);
        repeat (8) send(1'b1);
        check("lol_state_hunt", uo_out[3:2], 2'b00);
        check("lol_model_unlocked", uo_out[0], model_locked);
        check("lol_err_cnt", uio_out, exp_cnt);

        repeat (94) send(1'b0);
        check("relock_not_yet", uo_out[0], 0);
        send(1'b0);
        check("relock", uo_out[0], model_locked);

        // widely spaced flips never lose lock and saturate the counter
        for (int i = 0; i < 300; i++) begin
            gap = $urandom_range(33, 60);
            repeat (gap) send(1'b0);
            send(1'b1);
        end
        repeat (5) send(1'b0);
        check("sat_err_cnt", uio_out, exp_cnt);
        check("sat_locked", uo_out[0], model_locked);

        // clear wins over a simultaneous error, state untouched
        ui_in[1] = 1'b1;
        send(1'b1);
        ui_in[1] = 1'b0;
        check("clr_priority_cnt", uio_out, 0);
        check("clr_keeps_lock", uo_out[0], 1);
        repeat (3) send(1'b0);

        // asynchronous reset mid-lock
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");

        // inverted stream without inv never locks
        do_reset();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(~s[i+31]);
            if (uo_out[0] !== 1'b0) bad++;
        end
        check("inverted_no_lock", bad, 0);

        do_reset();
        ui_in[2]   = 1'b1;
        inv_stream = 1'b1;
        repeat (94) send(1'b0);
        check("inv_locked_after_94", uo_out[0], 0);
        send(1'b0);
        check("inv_locked_after_95", uo_out[0], model_locked);
        inv_stream = 1'b0;

        // all-zero input never locks
        do_reset();
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            drive(1'b0);
            if (uo_out[0] !== 1'b0 || uo_out[3:2] === 2'b10) bad++;
        end
        check("zeros_no_lock", bad, 0);

`ifdef PRBS31_CHK_SELFTEST_EN
        do_reset();
        ui_in[3] = 1'b1;
        for (int i = 0; i < 94; i++) drive(1'($urandom));
        check("st_locked_after_94", uo_out[0], 0);
        drive(1'($urandom));
        check("st_locked_after_95", uo_out[0], 1);
        ui_in[4] = 1'b1;
        exp_q.push_back(1);
        drive(1'($urandom));
        ui_in[4] = 1'b0;
        for (int i = 0; i < 20; i++) drive(1'($urandom));
        check("st_inj_err_cnt", uio_out, 1);
        check("st_inj_locked", uo_out[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("st_async_reset");
`else
        // without the self-test build, lpbk and inj must not disturb a real stream
        do_reset();
        ui_in[3] = 1'b1;
        ui_in[4] = 1'b1;
        repeat (94) send(1'b0);
        check("nost_locked_after_94", uo_out[0], 0);
        send(1'b0);
        check("nost_locked_after_95", uo_out[0], model_locked);
        repeat (50) send(1'b0);
        check("nost_err_cnt", uio_out, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
